// File: rtl/pc_unit.sv
// Program counter unit: boot/run/halt sequencing, trap and redirect steering,
// sequential fetch advance and a one-stage execute PC shadow.
module pc_unit #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = {XLEN{1'b0}},
    parameter int               IALIGN       = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_trap_valid,
    input  logic [XLEN-1:0] i_trap_vector,
    input  logic            i_halt_req,
    input  logic            i_resume,
    output logic [XLEN-1:0] o_pc_out,
    output logic [XLEN-1:0] o_pc_next_seq,
    output logic            o_fetch_valid,
    output logic [XLEN-1:0] o_pc_exe,
    output logic            o_pc_exe_valid,
    output logic            o_misalign_err
);

    localparam int              INC        = IALIGN / 8;
    localparam int              ALIGN_BITS = (IALIGN == 16) ? 1 : 2;
    localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << ALIGN_BITS;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic            r_err;
    logic            w_err_nxt;
    logic [XLEN-1:0] r_exe;
    logic            r_exe_valid;
    logic            w_flush;
    logic            w_run;
    logic            w_redir_aligned;
    logic [XLEN-1:0] w_trap_pc;
    logic [XLEN-1:0] w_pc_inc;

    assign w_run           = (r_state == ST_RUN);
    assign w_redir_aligned = ((i_redirect_pc & ~ALIGN_MASK) == {XLEN{1'b0}});
    assign w_trap_pc       = i_trap_vector & ALIGN_MASK;
    assign w_pc_inc        = r_pc + INC_V;
    // A redirect only flushes while running; traps flush from any state.
    assign w_flush         = i_trap_valid | (i_redirect_valid & w_run);

    // Next-state, next-PC and sticky misalignment flag selection.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_err_nxt   = r_err;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (i_trap_valid) begin
                    w_pc_nxt  = w_trap_pc;
                    w_err_nxt = 1'b0;
                end else if (i_redirect_valid) begin
                    if (w_redir_aligned) begin
                        w_pc_nxt = i_redirect_pc;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else if (i_halt_req) begin
                    w_state_nxt = ST_HALT;
                end else if (i_en) begin
                    w_pc_nxt = w_pc_inc;
                end else begin
                    w_pc_nxt = r_pc;
                end
            end
            ST_HALT: begin
                if (i_trap_valid) begin
                    w_pc_nxt    = w_trap_pc;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = ST_RUN;
                end else if (i_resume) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_HALT;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
                w_pc_nxt    = RESET_VECTOR;
                w_err_nxt   = 1'b0;
            end
        endcase
    end

    // State, fetch PC and misalignment flag registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_VECTOR;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Execute-stage PC shadow; a flush kills it even while stalled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_exe       <= RESET_VECTOR;
            r_exe_valid <= 1'b0;
        end else if (w_flush) begin
            r_exe_valid <= 1'b0;
        end else if (i_en) begin
            r_exe       <= r_pc;
            r_exe_valid <= w_run;
        end else begin
            r_exe       <= r_exe;
            r_exe_valid <= r_exe_valid;
        end
    end

    assign o_pc_out       = r_pc;
    assign o_pc_next_seq  = w_pc_inc;
    assign o_fetch_valid  = w_run;
    assign o_pc_exe       = r_exe;
    assign o_pc_exe_valid = r_exe_valid;
    assign o_misalign_err = r_err;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic
// compared against a behavioural model of the PC rules.
module tb_pc_unit;

    localparam logic [31:0] RV = 32'h8000_0000;
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_en = 1'b0;
    logic        i_redirect_valid = 1'b0;
    logic [31:0] i_redirect_pc = 32'd0;
    logic        i_trap_valid = 1'b0;
    logic [31:0] i_trap_vector = 32'd0;
    logic        i_halt_req = 1'b0;
    logic        i_resume = 1'b0;
    logic [31:0] o_pc_out;
    logic [31:0] o_pc_next_seq;
    logic        o_fetch_valid;
    logic [31:0] o_pc_exe;
    logic        o_pc_exe_valid;
    logic        o_misalign_err;

    int total = 0;
    int bad = 0;

    // Reference model state
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_exe;
    bit          m_exe_v;
    bit          m_err;

    pc_unit #(.XLEN(32), .RESET_VECTOR(32'h8000_0000), .IALIGN(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
        .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
        .i_trap_valid(i_trap_valid), .i_trap_vector(i_trap_vector),
        .i_halt_req(i_halt_req), .i_resume(i_resume),
        .o_pc_out(o_pc_out), .o_pc_next_seq(o_pc_next_seq),
        .o_fetch_valid(o_fetch_valid), .o_pc_exe(o_pc_exe),
        .o_pc_exe_valid(o_pc_exe_valid), .o_misalign_err(o_misalign_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic mdl_reset();
        m_mode = M_BOOT; m_pc = RV; m_exe = RV; m_exe_v = 0; m_err = 0;
    endtask

    task automatic mdl_edge();
        bit running;
        running = (m_mode == M_RUN);
        if (i_trap_valid || (i_redirect_valid && running)) m_exe_v = 0;
        else if (i_en) begin m_exe = m_pc; m_exe_v = running; end
        case (m_mode)
            M_BOOT: m_mode = M_RUN;
            M_RUN: begin
                if (i_trap_valid) begin m_pc = i_trap_vector - (i_trap_vector % 32'd4); m_err = 0; end
                else if (i_redirect_valid) begin
                    if (i_redirect_pc % 32'd4 == 32'd0) m_pc = i_redirect_pc;
                    else m_err = 1;
                end
                else if (i_halt_req) m_mode = M_HALT;
                else if (i_en) m_pc = m_pc + 32'd4;
            end
            M_HALT: begin
                if (i_trap_valid) begin
                    m_pc = i_trap_vector - (i_trap_vector % 32'd4); m_err = 0; m_mode = M_RUN;
                end else if (i_resume) m_mode = M_RUN;
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge i_clk);
        mdl_edge();
        #1;
    endtask

    task automatic clear_inputs();
        i_en = 0; i_redirect_valid = 0; i_trap_valid = 0; i_halt_req = 0; i_resume = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        i_rst = 1; mdl_reset();
        repeat (2) @(posedge i_clk);
        #1;
        total++;
        if (o_pc_out !== RV || o_pc_exe !== RV || o_fetch_valid !== 1'b0 ||
            o_pc_exe_valid !== 1'b0 || o_misalign_err !== 1'b0) begin
            bad++;
            $display("FAIL reset: pc=%h exe=%h fv=%b ev=%b err=%b want pc=%h exe=%h 0 0 0",
                     o_pc_out, o_pc_exe, o_fetch_valid, o_pc_exe_valid, o_misalign_err, RV, RV);
        end
    endtask

    task automatic test_seq();
        logic [31:0] exp_pc [3] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
        i_rst = 0; i_en = 1;
        #1;
        total++;
        if (o_pc_out !== RV || o_fetch_valid !== 1'b0) begin
            bad++; $display("FAIL boot: pc=%h fv=%b want %h 0", o_pc_out, o_fetch_valid, RV);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (o_pc_out !== exp_pc[k] || o_fetch_valid !== 1'b1) begin
                bad++; $display("FAIL seq%0d: pc=%h fv=%b want %h 1", k, o_pc_out, o_fetch_valid, exp_pc[k]);
            end
            if (k > 0) begin
                total++;
                if (o_pc_exe !== exp_pc[k-1] || o_pc_exe_valid !== 1'b1) begin
                    bad++; $display("FAIL exe_lag%0d: exe=%h ev=%b want %h 1", k, o_pc_exe, o_pc_exe_valid, exp_pc[k-1]);
                end
            end
        end
    endtask

    task automatic test_redirect();
        tick(); tick();
        total++;
        if (o_pc_out !== 32'h8000_0010) begin
            bad++; $display("FAIL pre_redirect: pc=%h want 80000010", o_pc_out);
        end
        i_en = 0; i_redirect_valid = 1; i_redirect_pc = 32'h8000_0100;
        tick();
        total++;
        if (o_pc_out !== 32'h8000_0100 || o_pc_exe_valid !== 1'b0) begin
            bad++; $display("FAIL redirect: pc=%h ev=%b want 80000100 0", o_pc_out, o_pc_exe_valid);
        end
        i_trap_valid = 1; i_trap_vector = 32'h0000_0203;
        tick();
        total++;
        if (o_pc_out !== 32'h0000_0200 || o_pc_exe_valid !== 1'b0) begin
            bad++; $display("FAIL trap_over_redirect: pc=%h ev=%b want 00000200 0", o_pc_out, o_pc_exe_valid);
        end
        clear_inputs();
    endtask

    task automatic test_misalign();
        i_en = 1; i_redirect_valid = 1; i_redirect_pc = 32'h8000_0102;
        tick();
        total++;
        if (o_pc_out !== 32'h0000_0200 || o_misalign_err !== 1'b1) begin
            bad++; $display("FAIL misalign: pc=%h err=%b want 00000200 1", o_pc_out, o_misalign_err);
        end
        i_redirect_valid = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (o_misalign_err !== 1'b1 || o_pc_out !== m_pc) begin
                bad++; $display("FAIL misalign_sticky%0d: err=%b pc=%h want 1 %h", k, o_misalign_err, o_pc_out, m_pc);
            end
        end
        i_trap_valid = 1; i_trap_vector = 32'h0000_0040;
        tick();
        total++;
        if (o_pc_out !== 32'h0000_0040 || o_misalign_err !== 1'b0) begin
            bad++; $display("FAIL misalign_clear: pc=%h err=%b want 00000040 0", o_pc_out, o_misalign_err);
        end
        clear_inputs();
    endtask

    task automatic test_halt();
        i_trap_valid = 1; i_trap_vector = 32'h8000_0020;
        tick();
        i_trap_valid = 0; i_halt_req = 1; i_en = 1;
        tick();
        total++;
        if (o_pc_out !== 32'h8000_0020 || o_fetch_valid !== 1'b0) begin
            bad++; $display("FAIL halt_enter: pc=%h fv=%b want 80000020 0", o_pc_out, o_fetch_valid);
        end
        i_halt_req = 0; i_redirect_valid = 1; i_redirect_pc = 32'h8000_1000;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (o_pc_out !== 32'h8000_0020 || o_fetch_valid !== 1'b0) begin
                bad++; $display("FAIL halt_hold%0d: pc=%h fv=%b want 80000020 0", k, o_pc_out, o_fetch_valid);
            end
        end
        i_redirect_valid = 0; i_resume = 1;
        tick();
        total++;
        if (o_pc_out !== 32'h8000_0020 || o_fetch_valid !== 1'b1) begin
            bad++; $display("FAIL resume: pc=%h fv=%b want 80000020 1", o_pc_out, o_fetch_valid);
        end
        i_resume = 0;
        tick();
        total++;
        if (o_pc_out !== 32'h8000_0024) begin
            bad++; $display("FAIL resume_adv: pc=%h want 80000024", o_pc_out);
        end
        clear_inputs();
    endtask

    task automatic test_wrap();
        i_en = 1; i_trap_valid = 1; i_trap_vector = 32'hFFFF_FFF8;
        tick();
        i_trap_valid = 0;
        total++;
        if (o_pc_out !== 32'hFFFF_FFF8 || o_pc_next_seq !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap0: pc=%h seq=%h want fffffff8 fffffffc", o_pc_out, o_pc_next_seq);
        end
        tick();
        total++;
        if (o_pc_out !== 32'hFFFF_FFFC || o_pc_next_seq !== 32'h0000_0000) begin
            bad++; $display("FAIL wrap1: pc=%h seq=%h want fffffffc 00000000", o_pc_out, o_pc_next_seq);
        end
        tick();
        total++;
        if (o_pc_out !== 32'h0000_0000) begin
            bad++; $display("FAIL wrap2: pc=%h want 00000000", o_pc_out);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            i_en             = ($urandom_range(3, 0) != 0);
            i_trap_valid     = ($urandom_range(15, 0) == 0);
            i_redirect_valid = ($urandom_range(7, 0) == 0);
            i_redirect_pc    = $urandom;
            if ($urandom_range(3, 0) != 0) i_redirect_pc[1:0] = 2'b00;
            i_trap_vector    = $urandom;
            i_halt_req       = ($urandom_range(15, 0) == 0);
            i_resume         = ($urandom_range(3, 0) == 0);
            tick();
            total++;
            if (o_pc_out !== m_pc || o_pc_next_seq !== m_pc + 32'd4 ||
                o_fetch_valid !== (m_mode == M_RUN) || o_pc_exe !== m_exe ||
                o_pc_exe_valid !== m_exe_v || o_misalign_err !== m_err) begin
                bad++;
                $display("FAIL random%0d: pc=%h seq=%h fv=%b exe=%h ev=%b err=%b want %h %h %b %h %b %b",
                         k, o_pc_out, o_pc_next_seq, o_fetch_valid, o_pc_exe, o_pc_exe_valid, o_misalign_err,
                         m_pc, m_pc + 32'd4, (m_mode == M_RUN), m_exe, m_exe_v, m_err);
            end
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        i_trap_valid = 1; i_trap_vector = 32'h8000_0041;
        tick();
        i_trap_valid = 0; i_redirect_valid = 1; i_redirect_pc = 32'h8000_0043;
        tick();
        total++;
        if (o_pc_out !== 32'h8000_0040 || o_fetch_valid !== 1'b1 || o_misalign_err !== 1'b1) begin
            bad++; $display("FAIL pre_async: pc=%h fv=%b err=%b want 80000040 1 1", o_pc_out, o_fetch_valid, o_misalign_err);
        end
        i_redirect_valid = 0; i_en = 1;
        tick();
        i_trap_valid = 1; i_trap_vector = 32'h0000_1000;
        #2;
        i_rst = 1; mdl_reset();
        #1;
        total++;
        if (o_pc_out !== RV || o_pc_exe_valid !== 1'b0 || o_fetch_valid !== 1'b0 || o_misalign_err !== 1'b0) begin
            bad++; $display("FAIL async_reset: pc=%h ev=%b fv=%b err=%b want %h 0 0 0",
                            o_pc_out, o_pc_exe_valid, o_fetch_valid, o_misalign_err, RV);
        end
        #1;
        i_rst = 0; i_trap_valid = 0;
        tick();
        total++;
        if (o_pc_out !== RV || o_fetch_valid !== 1'b1) begin
            bad++; $display("FAIL after_reset: pc=%h fv=%b want %h 1", o_pc_out, o_fetch_valid, RV);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_seq();
        test_redirect();
        test_misalign();
        test_halt();
        test_wrap();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
